// File: rtl/issue_pkg.sv
// Shared issue-queue sizing constants and one-hot/count types.
// The depth can be overridden globally by defining ISSUE_QUEUE_DEPTH before this file.
`ifndef ISSUE_QUEUE_DEPTH
`define ISSUE_QUEUE_DEPTH 8
`endif

package issue_pkg;

  localparam int IQ_DEPTH = `ISSUE_QUEUE_DEPTH;
  localparam int IQ_CNT_W = $clog2(IQ_DEPTH) + 1;

  typedef logic [IQ_DEPTH-1:0] iq_oh_t;
  typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

endpackage

// File: rtl/io_deq_ctrl_if.sv
// Handshake bundle between the enqueue policy / issue consumer (master)
// and the entry/dequeue controller (slave).
interface io_deq_ctrl_if
  import issue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             enq_fire;
  logic [DEPTH-1:0] enq_ptr_oh;
  logic             enq_src_ready;
  logic             enq_ready;
  logic [DEPTH-1:0] wakeup_oh;
  logic             issue_valid;
  logic             issue_ready;
  logic [DEPTH-1:0] issue_oh;
  logic [DEPTH-1:0] valid_dec;
  logic [DEPTH-1:0] enq_valid_oh;
  logic [DEPTH-1:0] deq_ptr_oh;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport master (
    output flush, enq_fire, enq_ptr_oh, enq_src_ready, wakeup_oh, issue_ready,
    input  enq_ready, issue_valid, issue_oh, valid_dec, enq_valid_oh,
           deq_ptr_oh, count, full, empty
  );

  modport slave (
    input  flush, enq_fire, enq_ptr_oh, enq_src_ready, wakeup_oh, issue_ready,
    output enq_ready, issue_valid, issue_oh, valid_dec, enq_valid_oh,
           deq_ptr_oh, count, full, empty
  );

endinterface

// File: rtl/io_deq_ctrl_oh_rotl.sv
// One-hot rotate-left by one position; the MSB wraps into the LSB.
module oh_rotl #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_oh,
  output logic [WIDTH-1:0] out_oh
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign out_oh[gi] = in_oh[(gi + WIDTH - 1) % WIDTH];
  end

endmodule

// File: rtl/io_deq_ctrl.sv
// In-order issue queue controller: per-entry valid/ready state, one-hot
// dequeue pointer, occupancy count, and head-of-queue issue handshake.
module io_deq_ctrl
  import issue_pkg::*;
#(
  parameter int DEPTH          = IQ_DEPTH,
  parameter bit CHECK_PROTOCOL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  io_deq_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid_q, valid_next;
  logic [DEPTH-1:0] rdy_q, rdy_next;
  logic [DEPTH-1:0] deq_q, deq_next, deq_rot;
  logic [DEPTH-1:0] enqv_q, enqv_next;
  logic [CW-1:0]    cnt_q, cnt_next;
  logic             full_w;
  logic             issue_valid_w;
  logic             issue_fire;
  logic             enq_acc;

  assign full_w        = (cnt_q == CW'(DEPTH));
  assign enq_acc       = bus.enq_fire & ~full_w & ~bus.flush;
  // Issue eligibility comes only from registers and flush, never from issue_ready.
  assign issue_valid_w = (|(deq_q & valid_q & rdy_q)) & ~bus.flush;
  assign issue_fire    = issue_valid_w & bus.issue_ready;

  oh_rotl #(.WIDTH(DEPTH)) u_rotl (
    .in_oh  (deq_q),
    .out_oh (deq_rot)
  );

  always_comb begin
    valid_next = valid_q;
    rdy_next   = rdy_q | (bus.wakeup_oh & valid_q);
    deq_next   = deq_q;
    cnt_next   = cnt_q;
    enqv_next  = '0;
    if (bus.flush) begin
      valid_next = '0;
      rdy_next   = '0;
      cnt_next   = '0;
    end else begin
      // A wakeup arriving with the enqueue still counts for the new entry.
      if (enq_acc) begin
        valid_next = valid_next | bus.enq_ptr_oh;
        rdy_next   = (rdy_next & ~bus.enq_ptr_oh) |
                     (bus.enq_ptr_oh & ({DEPTH{bus.enq_src_ready}} | bus.wakeup_oh));
        enqv_next  = bus.enq_ptr_oh;
      end
      if (issue_fire) begin
        valid_next = valid_next & ~deq_q;
        rdy_next   = rdy_next & ~deq_q;
        deq_next   = deq_rot;
      end
      if (enq_acc && !issue_fire) begin
        cnt_next = cnt_q + CW'(1);
      end else if (issue_fire && !enq_acc) begin
        cnt_next = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rdy_q   <= '0;
      deq_q   <= DEPTH'(1);
      cnt_q   <= '0;
      enqv_q  <= '0;
    end else begin
      valid_q <= valid_next;
      rdy_q   <= rdy_next;
      deq_q   <= deq_next;
      cnt_q   <= cnt_next;
      enqv_q  <= enqv_next;
    end
  end

  assign bus.enq_ready    = ~full_w;
  assign bus.full         = full_w;
  assign bus.empty        = (cnt_q == '0);
  assign bus.issue_valid  = issue_valid_w;
  assign bus.issue_oh     = issue_valid_w ? deq_q : '0;
  assign bus.valid_dec    = valid_q;
  assign bus.enq_valid_oh = enqv_q;
  assign bus.deq_ptr_oh   = deq_q;
  assign bus.count        = cnt_q;

  if (CHECK_PROTOCOL) begin : g_protocol
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        bus.enq_fire |-> !full_w)
      else $error("enq_fire while full: enqueue dropped");
    a_enq_onehot : assert property (@(posedge clock) disable iff (reset)
        bus.enq_fire |-> $onehot(bus.enq_ptr_oh))
      else $error("enq_ptr_oh not one-hot under enq_fire");
  end

endmodule
